// File: rtl/imm_encode_pkg.sv
// ----------------------------------------------------------------------------
// imm_encode_pkg
// Shared definitions for the immediate encoder: ImmSrc format codes, the
// controller state encoding, range limits for the LDR/STR and branch formats,
// and a 32-bit rotate-left helper used by the rotation checker.
// ----------------------------------------------------------------------------
package imm_encode_pkg;

  // ImmSrc format codes (00 is treated as branch, like 11)
  localparam logic [1:0] SRC_BR0 = 2'b00;
  localparam logic [1:0] SRC_DP  = 2'b01;
  localparam logic [1:0] SRC_LS  = 2'b10;
  localparam logic [1:0] SRC_BR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Largest offset magnitude an LDR/STR 12-bit immediate can hold
  localparam logic [31:0] LS_MAX_MAG = 32'd4095;

  // Branch byte-offset window: -2^25 .. 2^25-4
  localparam int BR_LIMIT = 1 << 25;
  localparam logic signed [31:0] BR_MIN = -BR_LIMIT;
  localparam logic signed [31:0] BR_MAX = BR_LIMIT - 4;

  // Last rotation tried by the data-processing search
  localparam logic [3:0] ROT_LAST = 4'd15;

  // Rotate a 32-bit word left by sh bits (0..31)
  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] sh);
    logic [63:0] dbl;
    dbl = {v, v} << sh;
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/imm_ext.sv
// ----------------------------------------------------------------------------
// imm_ext
// Combinational encoder for the single-cycle formats.
//   Value  : signed offset to encode
//   ImmSrc : format code (SRC_LS, or branch for SRC_BR / SRC_BR0)
//   Field  : Instr[23:0] immediate field, zero when the value does not fit
//   Fits   : value is representable in the requested format
// The data-processing code is not handled here; it yields Fits=0, Field=0.
// ----------------------------------------------------------------------------
module imm_ext
  import imm_encode_pkg::*;
(
  input  logic [31:0] Value,
  input  logic [1:0]  ImmSrc,
  output logic [23:0] Field,
  output logic        Fits
);

  logic signed [31:0] sval;
  logic [31:0]        mag;
  logic               ls_fits;
  logic               br_fits;

  always_comb begin
    sval = Value;
    // For 0x80000000 the negation wraps to itself, which is out of range anyway
    mag  = sval[31] ? (~Value + 32'd1) : Value;
    ls_fits = (mag <= LS_MAX_MAG);
    br_fits = (Value[1:0] == 2'b00) && (sval >= BR_MIN) && (sval <= BR_MAX);

    Field = 24'd0;
    Fits  = 1'b0;
    case (ImmSrc)
      SRC_LS: begin
        Fits = ls_fits;
        // U bit (bit 23) selects add vs subtract of the magnitude
        if (ls_fits) Field = {~sval[31], 11'd0, mag[11:0]};
      end
      SRC_BR, SRC_BR0: begin
        Fits = br_fits;
        if (br_fits) Field = Value[25:2];
      end
      default: begin
        Field = 24'd0;
        Fits  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_rot_check.sv
// ----------------------------------------------------------------------------
// imm_rot_check
// Combinational test of one data-processing rotation. The value is
// representable with rotation r when rotating it left by 2r leaves only the
// low 8 bits set; those 8 bits are then the imm8 field.
//   Value : 32-bit value under test
//   r     : rotation index 0..15 (actual rotate amount is 2r)
//   hit   : value fits with this rotation
//   imm8  : low byte of the rotated value
// ----------------------------------------------------------------------------
module imm_rot_check
  import imm_encode_pkg::*;
(
  input  logic [31:0] Value,
  input  logic [3:0]  r,
  output logic        hit,
  output logic [7:0]  imm8
);

  logic [31:0] rotated;

  always_comb begin
    rotated = rol32(Value, {r, 1'b0});
    hit     = (rotated[31:8] == 24'd0);
    imm8    = rotated[7:0];
  end

endmodule

// File: rtl/imm_encode.sv
// ----------------------------------------------------------------------------
// imm_encode
// Encodes a 32-bit value into the 24-bit immediate field of an instruction.
// Data-processing immediates are found by searching rotations 0..15, one per
// cycle, through a single shared imm_rot_check; the smallest hitting rotation
// wins. LDR/STR and branch offsets are encoded combinationally on accept.
// Ports:
//   CLK      : clock, rising edge
//   nReset   : asynchronous active-low reset
//   InValid  : request valid          InReady  : request can be accepted (IDLE)
//   Value    : value to encode        ImmSrc   : format code
//   OutValid : result valid (DONE)    OutReady : consumer takes result
//   Field    : encoded Instr[23:0]    Fits     : value is representable
// ----------------------------------------------------------------------------
module imm_encode
  import imm_encode_pkg::*;
(
  input  logic        CLK,
  input  logic        nReset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] Value,
  input  logic [1:0]  ImmSrc,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [23:0] Field,
  output logic        Fits
);

  state_e      state_q, state_d;
  logic [3:0]  r_q, r_d;
  logic [31:0] value_q, value_d;
  logic [23:0] field_q, field_d;
  logic        fits_q, fits_d;
  logic        out_valid_q;
  logic        in_ready_q;

  logic        accept;
  logic        rot_hit;
  logic [7:0]  rot_imm8;
  logic [23:0] ext_field;
  logic        ext_fits;

  imm_rot_check u_rot (
    .Value (value_q),
    .r     (r_q),
    .hit   (rot_hit),
    .imm8  (rot_imm8)
  );

  // Single-cycle formats are encoded straight from the request inputs so
  // the result is ready on the accept edge.
  imm_ext u_ext (
    .Value  (Value),
    .ImmSrc (ImmSrc),
    .Field  (ext_field),
    .Fits   (ext_fits)
  );

  // in_ready_q is only ever high in IDLE
  assign accept = InValid & in_ready_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    value_d = value_q;
    field_d = field_q;
    fits_d  = fits_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          value_d = Value;
          r_d     = 4'd0;
          if (ImmSrc == SRC_DP) begin
            state_d = ST_SEARCH;
            field_d = 24'd0;
            fits_d  = 1'b0;
          end else begin
            state_d = ST_DONE;
            field_d = ext_field;
            fits_d  = ext_fits;
          end
        end
      end

      ST_SEARCH: begin
        // Rotations are tried in ascending order, so the first hit is the smallest
        if (rot_hit) begin
          state_d = ST_DONE;
          fits_d  = 1'b1;
          field_d = {12'd0, r_q, rot_imm8};
        end else if (r_q == ROT_LAST) begin
          state_d = ST_DONE;
          fits_d  = 1'b0;
          field_d = 24'd0;
        end else begin
          r_d = r_q + 4'd1;
        end
      end

      ST_DONE: begin
        if (OutReady) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state, so InReady stays low
  // on the edge that leaves DONE and on the first edge out of reset.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state_q     <= ST_IDLE;
      r_q         <= 4'd0;
      value_q     <= 32'd0;
      field_q     <= 24'd0;
      fits_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      value_q     <= value_d;
      field_q     <= field_d;
      fits_q      <= fits_d;
      out_valid_q <= (state_d == ST_DONE);
      in_ready_q  <= (state_d == ST_IDLE);
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign Field    = field_q;
  assign Fits     = fits_q;

endmodule

// File: tb/tb_imm_encode.sv
module tb_imm_encode;

  localparam logic [1:0] DP = 2'b01;
  localparam logic [1:0] LS = 2'b10;
  localparam logic [1:0] BR = 2'b11;

  logic        CLK = 1'b0;
  logic        nReset = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [31:0] Value = 32'd0;
  logic [1:0]  ImmSrc = 2'b00;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [23:0] Field;
  logic        Fits;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [23:0] f;
    logic        fit;
    int          lat;
    logic        chk_lat;
  } exp_t;

  exp_t sb[$];

  imm_encode dut (
    .CLK      (CLK),
    .nReset   (nReset),
    .InValid  (InValid),
    .InReady  (InReady),
    .Value    (Value),
    .ImmSrc   (ImmSrc),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Field    (Field),
    .Fits     (Fits)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder
  function automatic exp_t model(input logic [31:0] v, input logic [1:0] src);
    exp_t e;
    longint sv;
    longint mag;
    logic [31:0] rot;
    e.f = 24'd0; e.fit = 1'b0; e.lat = 16; e.chk_lat = 1'b0;
    sv = longint'($signed(v));
    if (src == DP) begin
      e.chk_lat = 1'b1;
      for (int r = 0; r < 16; r++) begin
        rot = (r == 0) ? v : ((v << (2 * r)) | (v >> (32 - 2 * r)));
        if (rot[31:8] == 24'd0) begin
          e.fit = 1'b1;
          e.f   = {12'd0, r[3:0], rot[7:0]};
          e.lat = r + 1;
          break;
        end
      end
    end else if (src == LS) begin
      mag = (sv < 0) ? -sv : sv;
      if (mag <= 4095) begin
        e.fit = 1'b1;
        e.f   = {(sv >= 0), 11'd0, mag[11:0]};
      end
    end else begin
      if (v[1:0] == 2'b00 && sv >= -(64'sd1 << 25) && sv <= (64'sd1 << 25) - 4) begin
        e.fit = 1'b1;
        e.f   = v[25:2];
      end
    end
    return e;
  endfunction

  // One request: wait for InReady, issue, await result, hold OutReady low for
  // `hold` cycles (optionally poking InValid), then complete the handshake.
  task automatic do_txn(input logic [31:0] v, input logic [1:0] src, input int hold, input bit poke);
    exp_t e;
    int guard;
    int lat;
    guard = 0;
    @(negedge CLK);
    while (!InReady && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (!InReady) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    Value = v; ImmSrc = src; InValid = 1'b1;
    sb.push_back(model(v, src));
    @(posedge CLK); #1;
    InValid = 1'b0;
    lat = 0;
    while (!OutValid && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    e = sb.pop_front();
    if (!OutValid) begin
      check("outvalid_timeout", 32'd0, 32'd1);
      return;
    end
    check("field", {8'd0, Field}, {8'd0, e.f});
    check("fits", {31'd0, Fits}, {31'd0, e.fit});
    if (e.chk_lat) check("latency", lat, e.lat);
    if (poke) begin
      Value = 32'h0000_00AB; ImmSrc = DP; InValid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check("hold_valid", {31'd0, OutValid}, 32'd1);
      check("hold_field", {8'd0, Field}, {8'd0, e.f});
      check("hold_fits", {31'd0, Fits}, {31'd0, e.fit});
      check("hold_inready", {31'd0, InReady}, 32'd0);
    end
    @(negedge CLK);
    InValid = 1'b0;
    OutReady = 1'b1;
    @(posedge CLK); #1;
    check("release_valid", {31'd0, OutValid}, 32'd0);
    check("release_inready", {31'd0, InReady}, 32'd1);
    OutReady = 1'b0;
    if (poke) begin
      @(posedge CLK); #1;
      check("no_queued_req", {31'd0, OutValid}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  i8;
    int          rr;

    // Reset state
    #1;
    check("rst_valid", {31'd0, OutValid}, 32'd0);
    check("rst_inready", {31'd0, InReady}, 32'd0);
    check("rst_field", {8'd0, Field}, 32'd0);
    check("rst_fits", {31'd0, Fits}, 32'd0);
    repeat (2) @(negedge CLK);
    nReset = 1'b1;
    @(posedge CLK); #1;
    check("inready_after_rst", {31'd0, InReady}, 32'd1);

    // Data-processing directed cases
    do_txn(32'h0000_00FF, DP, 0, 1'b0);
    do_txn(32'hFF00_0000, DP, 0, 1'b0);
    do_txn(32'h0000_0101, DP, 0, 1'b0);
    do_txn(32'h0000_0000, DP, 0, 1'b0);
    do_txn(32'h0000_03FC, DP, 0, 1'b0);
    do_txn(32'hF000_000F, DP, 0, 1'b0);

    // LDR/STR
    do_txn(32'hFFFF_FFFC, LS, 0, 1'b0);
    do_txn(32'd4095, LS, 0, 1'b0);
    do_txn(32'd4096, LS, 0, 1'b0);
    do_txn(32'hFFFF_F001, LS, 0, 1'b0);
    do_txn(32'hFFFF_F000, LS, 0, 1'b0);

    // Branch, both codes
    do_txn(32'hFFFF_FFF8, BR, 0, 1'b0);
    do_txn(32'h0200_0000, BR, 0, 1'b0);
    do_txn(32'd6, BR, 0, 1'b0);
    do_txn(32'h01FF_FFFC, 2'b00, 0, 1'b0);
    do_txn(32'hFE00_0000, BR, 0, 1'b0);
    do_txn(32'hFDFF_FFFC, 2'b00, 0, 1'b0);

    // Backpressure with a second request offered while busy
    do_txn(32'h0000_3F00, DP, 10, 1'b1);

    // Random encodable and arbitrary DP values, random offsets
    for (int k = 0; k < 8; k++) begin
      i8 = 8'($urandom);
      rr = $urandom_range(0, 15);
      v  = {24'd0, i8};
      if (rr != 0) v = (v >> (2 * rr)) | (v << (32 - 2 * rr));
      do_txn(v, DP, $urandom_range(0, 2), 1'b0);
      do_txn($urandom, DP, 0, 1'b0);
      do_txn(32'($signed($urandom_range(0, 10000)) - 5000), LS, 0, 1'b0);
      do_txn($urandom & 32'h03FF_FFFC | (($urandom & 1) != 0 ? 32'hFC00_0000 : 32'h0), BR, 0, 1'b0);
    end

    // Reset in the middle of a long search
    @(negedge CLK);
    while (!InReady) @(negedge CLK);
    Value = 32'h0000_0101; ImmSrc = DP; InValid = 1'b1;
    sb.push_back(model(32'h0000_0101, DP));
    @(posedge CLK); #1;
    InValid = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    nReset = 1'b0;
    #1;
    check("midrst_valid", {31'd0, OutValid}, 32'd0);
    check("midrst_inready", {31'd0, InReady}, 32'd0);
    check("midrst_field", {8'd0, Field}, 32'd0);
    check("midrst_fits", {31'd0, Fits}, 32'd0);
    void'(sb.pop_back());
    @(negedge CLK);
    nReset = 1'b1;
    @(posedge CLK); #1;
    check("inready_after_midrst", {31'd0, InReady}, 32'd1);
    do_txn(32'h0000_00FF, DP, 0, 1'b0);

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imm_encode.md
IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port nReset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port InValid, input, 1, request valid.
REQ-004 SHALL have port InReady, output, 1, block can accept a request.
REQ-005 SHALL have port Value, input, 32, immediate or offset to encode.
REQ-006 SHALL have port ImmSrc, input, 2, format: 01 data-processing, 10 LDR/STR, 11 or 00 branch.
REQ-007 SHALL have port OutValid, output, 1, result valid.
REQ-008 SHALL have port OutReady, input, 1, consumer accepts result.
REQ-009 SHALL have port Field, output, 24, encoded Instr[23:0] immediate field.
REQ-010 SHALL have port Fits, output, 1, Value is representable in the requested format.

Function
REQ-011 SHALL implement the states IDLE, SEARCH and DONE.
REQ-012 SHALL assert InReady only in IDLE; a request is accepted on an edge where InValid and InReady are both high, and Value and ImmSrc are captured on that edge.
REQ-013 SHALL move, on accept, to SEARCH with rotation counter r=0 for ImmSrc 01, and to DONE on the next edge for all other formats.
REQ-014 SHALL, in SEARCH, test one rotation per cycle: a hit at r occurs when ROL(Value,2r)[31:8]==0.
REQ-015 SHALL, on a hit at r, go to DONE with Fits=1 and Field={12'b0, r[3:0], ROL(Value,2r)[7:0]}, so that OutValid rises r+1 edges after accept.
REQ-016 SHALL report the smallest hitting r when several rotations hit.
REQ-017 SHALL, if r=15 misses, go to DONE with Fits=0 and Field=0, so that OutValid rises 16 edges after accept.
REQ-018 SHALL, for LDR/STR, treat Value as a signed offset: if |Value|<=4095 then Fits=1 and Field={U, 11'b0, mag[11:0]} with U=1 for a non-negative Value; otherwise Fits=0 and Field=0.
REQ-019 SHALL, for branch, treat Value as a signed byte offset: Fits=1 only if Value[1:0]==0 and -2^25<=Value<=2^25-4, with Field=Value[25:2]; otherwise Fits=0 and Field=0.
REQ-020 SHALL assert OutValid only in DONE and hold Field and Fits stable while OutValid=1 and OutReady=0.
REQ-021 SHALL return from DONE to IDLE on the edge where OutValid and OutReady are both high; InReady stays low during that edge, so there is no same-cycle re-accept.
REQ-022 SHALL ignore InValid while not in IDLE; no queuing.

Reset
REQ-023 SHALL, on nReset=0 at any time including mid-SEARCH, immediately set state=IDLE, r=0, OutValid=0, Fits=0, Field=0 and InReady=0; the in-flight request is dropped.
REQ-024 SHALL assert InReady on the first rising edge after nReset deasserts.

Structure
REQ-025 SHALL place the ImmSrc codes, the state encoding, and the range constants (4095, 2^25) in a shared package that imm_encode and the extender both use.
REQ-026 SHALL use one combinational sub-module, imm_rot_check (inputs Value and r; outputs hit and imm8), instantiated once and time-shared across rotations.

Verification
REQ-027 SHALL cover: DP Value=0x000000FF -> Fits=1, Field=0x0000FF, OutValid 1 edge after accept.
REQ-028 SHALL cover: DP Value=0xFF000000 -> Fits=1, Field=0x0004FF, OutValid 5 edges after accept; and DP Value=0x00000101 -> Fits=0, Field=0, OutValid 16 edges after accept.
REQ-029 SHALL cover LDR/STR: Value=0xFFFFFFFC -> Field=0x000004, Fits=1; Value=4095 -> Field=0x800FFF, Fits=1; Value=4096 -> Fits=0, Field=0.
REQ-030 SHALL cover branch: Value=0xFFFFFFF8 -> Field=0xFFFFFE, Fits=1; Value=0x02000000 -> Fits=0; Value=6 -> Fits=0.
REQ-031 SHALL cover backpressure: OutReady held low for 10 cycles -> OutValid, Field and Fits are constant and a second InValid is not accepted; OutReady=1 -> IDLE on the next edge.
REQ-032 SHALL cover reset mid-operation: nReset pulsed low during the SEARCH of Value=0x00000101 -> OutValid=0 immediately, and a fresh request for 0xFF is accepted and encodes correctly after release.
